key_step_gen: RTL
=================

Name: key_step_gen

Overview:
- Upstream stage for the 16-bit hex-display counter. Turns a raw, bouncy, active-low pushbutton into clean single-cycle `step` pulses; the downstream counter's enable connects to `step`.
- Provides debouncing on both press and release, plus optional hold-to-auto-repeat.
- Runs on the board clock, so the counter no longer needs a pushbutton as its clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-low/high cycles required to accept a press/release (20 ms at 50 MHz); min 2.
- REPEAT_DELAY, 25000000, cycles held after the accepted press before the first repeat pulse; min 2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; min 2.
- CNT_W, 25, timer width; must hold max(all three)-1.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw pushbutton, asynchronous, 0 = pressed.
- repeat_en  in  1  1 = auto-repeat while held; sampled every cycle.
- step  out  1  registered one-cycle pulse per accepted press or repeat.
- pressed  out  1  registered debounced key level, 1 = held.

Behaviour:
- Interface: one clock, `clock`. Reset is synchronous and active-high on `reset`; these are fixed.
- Reset values: step=0, pressed=0, state=IDLE, timer=0, both synchronizer flops=1 (released). No pulse is emitted during or because of reset.
- Synchronizer: key_s is key_n through two flops, i.e. 2 cycles of latency.
- FSM, evaluated every edge on key_s:
  - IDLE: key_s=0 -> PRESS_WAIT, timer=0.
  - PRESS_WAIT:
    - key_s=1 -> IDLE (bounce rejected, no pulse).
    - Otherwise timer++.
    - At timer==DEBOUNCE_CYCLES-1 -> HELD, timer=0, step=1, pressed=1.
  - HELD:
    - key_s=1 -> RELEASE_WAIT, timer=0.
    - Else if repeat_en: timer++. At timer==REPEAT_DELAY-1 -> REPEAT, timer=0, step=1.
    - Else timer held at 0.
  - REPEAT:
    - key_s=1 -> RELEASE_WAIT, timer=0.
    - Else if !repeat_en -> HELD, timer=0.
    - Else timer++. At timer==REPEAT_PERIOD-1 -> timer=0, step=1 (stay in REPEAT).
  - RELEASE_WAIT:
    - key_s=0 -> HELD, timer=0 (release bounce, no pulse, pressed stays 1).
    - Otherwise timer++.
    - At timer==DEBOUNCE_CYCLES-1 -> IDLE, pressed=0.
- step is 0 in every cycle not listed above; it is never high for two consecutive cycles.
- Latency: key_n low and stable from edge k gives step high for exactly the cycle after edge k+2+DEBOUNCE_CYCLES; pressed rises in the same cycle.
- Simultaneous events, in priority order:
  - reset over everything.
  - key_s change over timer terminal count. A release at the repeat terminal edge gives no pulse.
  - repeat_en=0 at the REPEAT terminal edge gives no pulse.
- Reset mid-operation: all state returns to reset values next cycle. A still-held key is re-debounced from IDLE, because the synchronizer reloads 1.
- Timer never wraps; it is always cleared on every state transition.

Decomposition:
- Shared package key_step_pkg:
  - state encoding localparams IDLE=0, PRESS_WAIT=1, HELD=2, REPEAT=3, RELEASE_WAIT=4 (3 bits).
  - default timing constants for 50 MHz.
- One sub-module sync_2ff:
  - 2-flop synchronizer with synchronous reset value parameter RST_VAL.
  - reusable for switch inputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=4):
- Reset: reset=1 for 3 cycles with key_n=0 -> step=0 and pressed=0 throughout. After reset drops at edge 0: step pulse after edge 6, pressed=1 from then.
- Clean press, repeat_en=0: key_n low from edge 0 for 50 cycles -> exactly one step (cycle after edge 6). Release at edge 50 -> pressed falls after edge 56, no further step.
- Press bounce: key_n low 3 cycles, high 1, repeated 5 times, then high -> zero step pulses, pressed stays 0.
- Auto-repeat, repeat_en=1: key_n low from edge 0 for 40 cycles -> steps after edges 6, 16, 19, 22, 25, 28, 31, 34, 37, 40, each exactly one cycle wide.
- Release bounce: in HELD, key_n high 2 cycles, low 1, then high -> no step, pressed stays 1 until 2+4 edges after the final rise, then 0.
- Reset mid-REPEAT: reset pulse 1 cycle at edge 20 with key held -> step=0 and pressed=0 next cycle. The next step comes 2+4 edges after reset deasserts, then the repeat sequence restarts from REPEAT_DELAY.

Source files
------------

// File: rtl/key_step_pkg.sv
// Shared encodings and 50 MHz timing defaults for the pushbutton step generator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package key_step_pkg;

  // Default timing at a 50 MHz board clock
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms before first repeat
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms between repeats
  localparam int DEF_CNT_W           = 25;

  // Debounce / repeat FSM states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/key_step_gen_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous switch/button inputs.
// Latency: 2 clock cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; reset loads the idle level so nothing looks like an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// Debounces an active-low pushbutton into one-cycle step pulses, with optional hold-to-repeat.
// Latency: step/pressed rise 2 + DEBOUNCE_CYCLES edges after key_n settles low.
// Backpressure: none; step is a fire-and-forget enable for the downstream counter.
module key_step_gen
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic repeat_en,
  output logic step,
  output logic pressed
);

  // Terminal counts: the timer counts 0..N-1, so N edges after entering a state
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_s;
  state_t           state;
  logic [CNT_W-1:0] timer;

  // Released level on reset, so a key held through reset is re-debounced
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  // Debounce/repeat FSM; a key level change always wins over a timer terminal count
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      step    <= 1'b0;
      pressed <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!key_s) begin
            state <= PRESS_WAIT;
          end
        end

        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state   <= HELD;
            timer   <= '0;
            step    <= 1'b1;
            pressed <= 1'b1;
          end else begin
            timer <= timer + CNT_ONE;
          end
        end

        HELD: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            timer <= '0;
          end else if (repeat_en) begin
            if (timer == RD_LAST) begin
              state <= REPEAT;
              timer <= '0;
              step  <= 1'b1;
            end else begin
              timer <= timer + CNT_ONE;
            end
          end else begin
            // Repeat disabled: hold the delay timer parked at zero
            timer <= '0;
          end
        end

        REPEAT: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            timer <= '0;
          end else if (!repeat_en) begin
            state <= HELD;
            timer <= '0;
          end else if (timer == RP_LAST) begin
            timer <= '0;
            step  <= 1'b1;
          end else begin
            timer <= timer + CNT_ONE;
          end
        end

        RELEASE_WAIT: begin
          if (!key_s) begin
            // Release bounce: back to held, repeat delay restarts
            state <= HELD;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state   <= IDLE;
            timer   <= '0;
            pressed <= 1'b0;
          end else begin
            timer <= timer + CNT_ONE;
          end
        end

        default: begin
          state   <= IDLE;
          timer   <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
